// File: rtl/ccff_loader.sv
// ccff_loader: streams host bitstream words, LSB first, into a serial
// configuration flip-flop chain of CHAIN_LEN bits.
//
// Ports:
//   prog_clk   programming clock
//   pReset_n   asynchronous active-low reset
//   start      begins a load (honoured only in IDLE)
//   abort      terminates a load in progress (LOAD/SHIFT)
//   s_data     bitstream word, bit 0 shifted first
//   s_valid    s_data valid
//   s_ready    loader accepts s_data this cycle (LOAD only)
//   ccff_head  serial bit into the chain head
//   ccff_tail  serial bit returned from the chain tail
//   shift_en   chain clock enable; the chain shifts on every edge where it is 1
//   busy       load in progress (LOAD/SHIFT)
//   done       one-cycle pulse after the last bit has shifted
//   crc_out    CRC-16-CCITT of the tail stream (only with CCFF_LOADER_CRC_EN)
//
// Build option: define CCFF_LOADER_CRC_EN to add crc_out and its logic.
module ccff_loader #(
    parameter int unsigned CHAIN_LEN = 36,
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              shift_en,
    output logic              busy,
    output logic              done
`ifdef CCFF_LOADER_CRC_EN
    ,
    output logic [15:0]       crc_out
`endif
);

    localparam int unsigned WCNT_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0]  LAST_TOTAL = CNT_W'(CHAIN_LEN);
    localparam logic [WCNT_W-1:0] LAST_WORD  = WCNT_W'(WORD_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_n;
    logic [WORD_W-1:0]   r_sr;
    logic [WORD_W-1:0]   w_sr_n;
    logic [CNT_W-1:0]    r_total;
    logic [CNT_W-1:0]    w_total_n;
    logic [CNT_W-1:0]    w_total_inc;
    logic [WCNT_W-1:0]   r_wcnt;
    logic [WCNT_W-1:0]   w_wcnt_n;
    logic [WCNT_W-1:0]   w_wcnt_inc;
    logic                w_start_acc;

    logic                r_s_ready;
    logic                r_ccff_head;
    logic                r_shift_en;
    logic                r_busy;
    logic                r_done;

    assign w_total_inc = r_total + CNT_W'(1);
    assign w_wcnt_inc  = r_wcnt + WCNT_W'(1);

    // Next-state, shift register and counter update
    always_comb begin
        w_state_n   = r_state;
        w_sr_n      = r_sr;
        w_total_n   = r_total;
        w_wcnt_n    = r_wcnt;
        w_start_acc = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    w_total_n   = '0;
                    w_state_n   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    w_state_n = ST_IDLE;
                end else if (s_valid && r_s_ready) begin
                    w_sr_n    = s_data;
                    w_wcnt_n  = '0;
                    w_state_n = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    w_state_n = ST_IDLE;
                end else begin
                    w_sr_n    = r_sr >> 1;
                    w_total_n = w_total_inc;
                    w_wcnt_n  = w_wcnt_inc;
                    // Chain end wins over word end: surplus word bits are dropped
                    if (w_total_inc == LAST_TOTAL) begin
                        w_state_n = ST_DONE;
                    end else if (w_wcnt_inc == LAST_WORD) begin
                        w_state_n = ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                w_state_n = ST_IDLE;
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    // State/data registers; outputs are registered decodes of the next state
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            r_state     <= ST_IDLE;
            r_sr        <= '0;
            r_total     <= '0;
            r_wcnt      <= '0;
            r_s_ready   <= 1'b0;
            r_ccff_head <= 1'b0;
            r_shift_en  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_sr        <= w_sr_n;
            r_total     <= w_total_n;
            r_wcnt      <= w_wcnt_n;
            r_s_ready   <= (w_state_n == ST_LOAD);
            r_ccff_head <= (w_state_n == ST_SHIFT) && w_sr_n[0];
            r_shift_en  <= (w_state_n == ST_SHIFT);
            r_busy      <= (w_state_n == ST_LOAD) || (w_state_n == ST_SHIFT);
            r_done      <= (w_state_n == ST_DONE);
        end
    end

    assign s_ready   = r_s_ready;
    assign ccff_head = r_ccff_head;
    assign shift_en  = r_shift_en;
    assign busy      = r_busy;
    assign done      = r_done;

`ifdef CCFF_LOADER_CRC_EN
    logic [15:0] r_crc;
    logic        w_crc_fb;

    assign w_crc_fb = r_crc[15] ^ ccff_tail;

    // Bit-serial CRC-16-CCITT over the bits leaving the chain tail
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            r_crc <= 16'hFFFF;
        end else if (w_start_acc) begin
            r_crc <= 16'hFFFF;
        end else if (r_shift_en) begin
            r_crc <= {r_crc[14:0], 1'b0} ^ (w_crc_fb ? 16'h1021 : 16'h0000);
        end
    end

    assign crc_out = r_crc;
`else
    logic w_unused_tail;
    assign w_unused_tail = ccff_tail ^ w_start_acc;
`endif

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 The module SHALL have parameter CHAIN_LEN, default 36, giving the number of configuration bits in the downstream ccff chain (18 two-bit mux memories).
REQ-002 The module SHALL have parameter WORD_W, default 8, giving the width of the host bitstream word.
REQ-003 The module SHALL have parameter CNT_W, default 16, giving the width of the total-bit counter; CHAIN_LEN SHALL be at most 2^CNT_W - 1.
REQ-004 prog_clk  in  1  programming clock, the single clock of the block.
REQ-005 pReset_n  in  1  reset, asynchronous and active-low.
REQ-006 start  in  1  pulse that begins a chain load.
REQ-007 abort  in  1  pulse that terminates a load in progress.
REQ-008 s_data  in  WORD_W  bitstream word; bit 0 is shifted first.
REQ-009 s_valid  in  1  s_data is valid.
REQ-010 s_ready  out  1  loader accepts s_data this cycle.
REQ-011 ccff_head  out  1  serial bit driven into the chain head.
REQ-012 ccff_tail  in  1  serial bit returned from the chain tail.
REQ-013 shift_en  out  1  chain clock enable, consumed by the external clock gate; the chain shifts on every prog_clk edge where shift_en=1.
REQ-014 busy  out  1  a load is in progress.
REQ-015 done  out  1  one-cycle pulse when the last bit has shifted.

Function
REQ-016 The FSM SHALL have four states: IDLE, LOAD, SHIFT and DONE.
REQ-017 IDLE: start=1 SHALL clear the total-bit counter and enter LOAD on the next cycle.
REQ-018 LOAD: s_ready SHALL be 1; on s_valid&s_ready the word SHALL be captured into an internal shift register, the per-word bit counter cleared, and the FSM SHALL enter SHIFT.
REQ-019 SHIFT: shift_en SHALL be 1 and ccff_head SHALL equal shift-register bit 0; each cycle the register SHALL shift right by one, and the word and total counters SHALL increment.
REQ-020 SHIFT exit: when the total reaches CHAIN_LEN the FSM SHALL enter DONE; otherwise, when WORD_W bits of the word are consumed, it SHALL enter LOAD.
REQ-021 Surplus bits of the final word beyond CHAIN_LEN SHALL be discarded and SHALL never be shifted.
REQ-022 Host stall: while s_valid=0 in LOAD, shift_en SHALL stay 0 and the chain contents SHALL be preserved.
REQ-023 Word bubble: each word SHALL cost exactly one LOAD cycle with shift_en=0; shift_en SHALL be high for exactly CHAIN_LEN cycles per completed load.
REQ-024 DONE: done SHALL be 1 for one cycle, then the FSM SHALL return to IDLE.
REQ-025 busy SHALL be 1 in LOAD and SHIFT and 0 in IDLE and DONE.
REQ-026 s_ready SHALL be 1 only in LOAD.
REQ-027 start SHALL be ignored in every state other than IDLE.
REQ-028 abort SHALL be honoured in LOAD and SHIFT, SHALL take priority over every other event in the same cycle, SHALL force IDLE on the next cycle with shift_en=0, and SHALL NOT produce done.
REQ-029 In IDLE and DONE, ccff_head SHALL be 0 and shift_en SHALL be 0.

Reset
REQ-030 Asserting pReset_n=0 SHALL immediately force IDLE and drive s_ready=0, ccff_head=0, shift_en=0, busy=0 and done=0, and SHALL clear all counters and the shift register, including during a load in progress.

Configuration
REQ-031 With CCFF_LOADER_CRC_EN defined, the module SHALL add output port crc_out[15:0]: CRC-16-CCITT (polynomial 0x1021), initialised to 0xFFFF on an accepted start and on reset, advanced by ccff_tail on every cycle with shift_en=1, and held otherwise.
REQ-032 Without CCFF_LOADER_CRC_EN, the crc_out port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-033 Basic load (CHAIN_LEN=36, WORD_W=8), start followed by 5 words with s_valid held at 1 -> shift_en high for 36 cycles in 5 runs (8,8,8,8,4); the ccff_head sequence equals the word bits LSB-first; done pulses once; word 5 bits [7:4] are never shifted.
REQ-034 Stall, s_valid=0 for 3 cycles before word 3 -> shift_en=0 for those cycles; the bit sequence is identical to REQ-033; done is delayed by 3 cycles.
REQ-035 Abort after 10 shifted bits -> busy=0 and shift_en=0 on the next cycle; no done pulse; a following start restarts at bit 0.
REQ-036 start pulsed during SHIFT -> ignored; the load completes with exactly 36 shifts.
REQ-037 pReset_n low during bit 20 -> all outputs at their reset values immediately; a new load after release is correct.
REQ-038 CCFF_LOADER_CRC_EN with a 36-cycle delay-line chain model -> crc_out equals the bit-serial reference model; start immediately followed by abort -> crc_out=16'hFFFF.
